keypad_loader: RTL and testbench

Keypad entry and load sequencer that drives the MM:SS countdown timer's `data`/`load`/`enable` inputs from a decimal keypad. It collects up to three typed digits (minutes, tens of seconds, seconds) and validates them. It then writes them serially into the timer's digit-shift load port and controls run, pause and stop from the timer's `zero` flag. It sits between the keypad scanner and the timer, and is the writer side of the timer's load interface.

---
 rtl/keypad_loader.sv | 168 ++++++++++++++++
 tb/tb_keypad_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_loader.sv
// Keypad entry and serial load sequencer for the MM:SS countdown timer.
// Build option: KEYPAD_AUTOSTART_EN makes LOAD fall straight into RUN instead of ARMED.
module keypad_loader (
  input  logic       clk,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       timer_zero,
  output logic [3:0] data,
  output logic       load,
  output logic       enable,
  output logic [3:0] dmin,
  output logic [3:0] dst,
  output logic [3:0] dso,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ARMED = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  localparam logic [3:0] KEY_CLEAR = 4'd10;
  localparam logic [3:0] KEY_START = 4'd11;
  localparam logic [3:0] KEY_STOP  = 4'd12;

  state_t     state_q;
  logic [1:0] idx_q;
  logic [3:0] data_q;
  logic       load_q;
  logic       enable_q;
  logic [3:0] dmin_q;
  logic [3:0] dst_q;
  logic [3:0] dso_q;
  logic       done_q;
  logic       err_q;

  logic key_digit;
  logic key_clear;
  logic key_start;
  logic key_stop;
  logic buf_empty;
  logic buf_bad;

  assign key_digit = key_valid && (key_code <= 4'd9);
  assign key_clear = key_valid && (key_code == KEY_CLEAR);
  assign key_start = key_valid && (key_code == KEY_START);
  assign key_stop  = key_valid && (key_code == KEY_STOP);
  assign buf_empty = (dmin_q == 4'd0) && (dst_q == 4'd0) && (dso_q == 4'd0);
  // Tens of seconds above 5 is not a valid time, so START is refused.
  assign buf_bad   = (dst_q > 4'd5);

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state_q  <= S_IDLE;
      idx_q    <= 2'd0;
      data_q   <= 4'd0;
      load_q   <= 1'b0;
      enable_q <= 1'b0;
      dmin_q   <= 4'd0;
      dst_q    <= 4'd0;
      dso_q    <= 4'd0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          load_q   <= 1'b0;
          enable_q <= 1'b0;
          if (key_digit) begin
            dmin_q <= dst_q;
            dst_q  <= dso_q;
            dso_q  <= key_code;
          end else if (key_clear) begin
            dmin_q <= 4'd0;
            dst_q  <= 4'd0;
            dso_q  <= 4'd0;
          end else if (key_start && !buf_empty) begin
            if (buf_bad) begin
              err_q <= 1'b1;
            end else begin
              state_q <= S_LOAD;
              idx_q   <= 2'd0;
              load_q  <= 1'b1;
              data_q  <= dmin_q;
            end
          end
        end
        S_LOAD: begin
          // The timer shifts toward min, so digits go out min first, so last.
          case (idx_q)
            2'd0: begin
              data_q <= dst_q;
              idx_q  <= 2'd1;
            end
            2'd1: begin
              data_q <= dso_q;
              idx_q  <= 2'd2;
            end
            default: begin
              data_q <= 4'd0;
              load_q <= 1'b0;
              idx_q  <= 2'd0;
`ifdef KEYPAD_AUTOSTART_EN
              state_q  <= S_RUN;
              enable_q <= 1'b1;
`else
              state_q  <= S_ARMED;
              enable_q <= 1'b0;
`endif
            end
          endcase
        end
        S_ARMED: begin
          if (key_start) begin
            state_q  <= S_RUN;
            enable_q <= 1'b1;
          end else if (key_clear) begin
            state_q <= S_IDLE;
            dmin_q  <= 4'd0;
            dst_q   <= 4'd0;
            dso_q   <= 4'd0;
          end
        end
        S_RUN: begin
          // Reaching zero outranks any key arriving in the same cycle.
          if (timer_zero) begin
            state_q  <= S_IDLE;
            enable_q <= 1'b0;
            done_q   <= 1'b1;
            dmin_q   <= 4'd0;
            dst_q    <= 4'd0;
            dso_q    <= 4'd0;
          end else if (key_stop) begin
            state_q  <= S_ARMED;
            enable_q <= 1'b0;
          end else if (key_clear) begin
            state_q  <= S_IDLE;
            enable_q <= 1'b0;
            dmin_q   <= 4'd0;
            dst_q    <= 4'd0;
            dso_q    <= 4'd0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          load_q   <= 1'b0;
          enable_q <= 1'b0;
        end
      endcase
    end
  end

  assign data   = data_q;
  assign load   = load_q;
  assign enable = enable_q;
  assign dmin   = dmin_q;
  assign dst    = dst_q;
  assign dso    = dso_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_keypad_loader.sv
// Bench for keypad_loader: directed scenarios with literal expectations plus
// random key traffic checked every cycle against a sequence-level model.
module tb_keypad_loader;

  logic       clk = 1'b0;
  logic       clearn = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic       timer_zero = 1'b0;
  logic [3:0] data;
  logic       load;
  logic       enable;
  logic [3:0] dmin;
  logic [3:0] dst;
  logic [3:0] dso;
  logic       done;
  logic       err;

  keypad_loader dut (
    .clk        (clk),
    .clearn     (clearn),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .timer_zero (timer_zero),
    .data       (data),
    .load       (load),
    .enable     (enable),
    .dmin       (dmin),
    .dst        (dst),
    .dso        (dso),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  // Model: typed digits, a queue of digits still to be presented on the load
  // port, and two flags saying whether a countdown is armed or running.
  int m_d[3];
  int seq[$];
  bit m_load, m_en, m_armed, m_run, m_done, m_err;
  int m_data;

  task automatic chk(string name, logic [3:0] act, int exp);
    total++;
    if ($isunknown(act) || int'(act) != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_d = '{0, 0, 0};
    seq.delete();
    m_load = 0; m_en = 0; m_armed = 0; m_run = 0; m_done = 0; m_err = 0;
    m_data = 0;
  endtask

  task automatic model_clear_buf();
    m_d = '{0, 0, 0};
  endtask

  task automatic model_step(bit kv, int kc, bit tz);
    m_done = 0;
    m_err = 0;
    if (m_load) begin
      if (seq.size() > 0) begin
        m_data = seq.pop_front();
      end else begin
        m_load = 0;
        m_data = 0;
`ifdef KEYPAD_AUTOSTART_EN
        m_run = 1;
        m_en = 1;
`else
        m_armed = 1;
`endif
      end
    end else if (m_run) begin
      if (tz) begin
        m_done = 1; m_run = 0; m_en = 0; model_clear_buf();
      end else if (kv && kc == 12) begin
        m_run = 0; m_armed = 1; m_en = 0;
      end else if (kv && kc == 10) begin
        m_run = 0; m_en = 0; model_clear_buf();
      end
    end else if (m_armed) begin
      if (kv && kc == 11) begin
        m_armed = 0; m_run = 1; m_en = 1;
      end else if (kv && kc == 10) begin
        m_armed = 0; model_clear_buf();
      end
    end else if (kv) begin
      if (kc <= 9) begin
        m_d[0] = m_d[1]; m_d[1] = m_d[2]; m_d[2] = kc;
      end else if (kc == 10) begin
        model_clear_buf();
      end else if (kc == 11 && (m_d[0] + m_d[1] + m_d[2]) != 0) begin
        if (m_d[1] > 5) begin
          m_err = 1;
        end else begin
          m_load = 1;
          m_data = m_d[0];
          seq.push_back(m_d[1]);
          seq.push_back(m_d[2]);
        end
      end
    end
  endtask

  task automatic cyc(bit kv, int kc, bit tz);
    key_valid = kv;
    key_code = kc[3:0];
    timer_zero = tz;
    @(posedge clk);
    model_step(kv, kc, tz);
    #1;
    key_valid = 1'b0;
    timer_zero = 1'b0;
  endtask

  task automatic load_and_start();
    cyc(1, 11, 0);
    repeat (3) cyc(0, 0, 0);
`ifndef KEYPAD_AUTOSTART_EN
    cyc(1, 11, 0);
`endif
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("data", data, m_data);
      chk("load", {3'd0, load}, int'(m_load));
      chk("enable", {3'd0, enable}, int'(m_en));
      chk("dmin", dmin, m_d[0]);
      chk("dst", dst, m_d[1]);
      chk("dso", dso, m_d[2]);
      chk("done", {3'd0, done}, int'(m_done));
      chk("err", {3'd0, err}, int'(m_err));
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_load", {3'd0, load}, 0);
    chk("rst_enable", {3'd0, enable}, 0);
    chk("rst_data", data, 0);
    chk("rst_dmin", dmin, 0);
    clearn = 1'b1;
    check_en = 1'b1;

    // 1,3,0 START: buffer, three load cycles, then run/armed
    cyc(1, 1, 0); cyc(1, 3, 0); cyc(1, 0, 0);
    chk("a_dmin", dmin, 1); chk("a_dst", dst, 3); chk("a_dso", dso, 0);
    cyc(1, 11, 0);
    chk("a_load0", {3'd0, load}, 1); chk("a_data0", data, 1);
    cyc(1, 5, 0);
    chk("a_data1", data, 3); chk("a_dso_hold", dso, 0);
    cyc(0, 0, 0);
    chk("a_data2", data, 0); chk("a_load2", {3'd0, load}, 1);
    cyc(0, 0, 0);
    chk("a_load_end", {3'd0, load}, 0);
`ifdef KEYPAD_AUTOSTART_EN
    chk("a_en_auto", {3'd0, enable}, 1);
`else
    chk("a_en_armed", {3'd0, enable}, 0);
    cyc(1, 11, 0);
    chk("a_en_start", {3'd0, enable}, 1);
`endif
    cyc(1, 12, 0);
    chk("a_stop", {3'd0, enable}, 0);
    cyc(1, 11, 0);
    chk("a_restart", {3'd0, enable}, 1);

    // asynchronous reset in RUN
    #2;
    check_en = 1'b0;
    clearn = 1'b0;
    #1;
    chk("arst_enable", {3'd0, enable}, 0);
    chk("arst_load", {3'd0, load}, 0);
    model_reset();
    @(posedge clk);
    #1;
    clearn = 1'b1;
    chk("arst_dmin", dmin, 0);
    check_en = 1'b1;

    // 2,7,5 START is rejected, then CLEAR
    cyc(1, 2, 0); cyc(1, 7, 0); cyc(1, 5, 0); cyc(1, 11, 0);
    chk("b_err", {3'd0, err}, 1); chk("b_load", {3'd0, load}, 0); chk("b_dst", dst, 7);
    cyc(0, 0, 0);
    chk("b_err_end", {3'd0, err}, 0);
    cyc(1, 10, 0);
    chk("b_clear", dst, 0);

    // START on an empty buffer does nothing
    cyc(1, 11, 0);
    chk("c_load", {3'd0, load}, 0); chk("c_err", {3'd0, err}, 0);

    // zero wins over a simultaneous STOP
    cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 5, 0);
    load_and_start();
    cyc(1, 12, 1);
    chk("d_done", {3'd0, done}, 1); chk("d_en", {3'd0, enable}, 0); chk("d_dso", dso, 0);
    cyc(1, 4, 0);
    chk("d_done_end", {3'd0, done}, 0); chk("d_idle_digit", dso, 4);

    // asynchronous reset in LOAD
    cyc(1, 2, 0); cyc(1, 3, 0); cyc(1, 11, 0); cyc(0, 0, 0);
    #2;
    check_en = 1'b0;
    clearn = 1'b0;
    #1;
    chk("lrst_load", {3'd0, load}, 0);
    model_reset();
    @(posedge clk);
    #1;
    clearn = 1'b1;
    check_en = 1'b1;

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      int kc;
      r = $urandom_range(0, 19);
      if (r < 10) kc = r;
      else if (r < 12) kc = 10;
      else if (r < 17) kc = 11;
      else if (r < 19) kc = 12;
      else kc = $urandom_range(13, 15);
      cyc($urandom_range(0, 2) == 0, kc, $urandom_range(0, 15) == 0);
    end

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
